// File: rtl/vram_scan_arbiter.sv
// rtl/vram_scan_arbiter.sv - VRAM arbiter between rasterizer and scanout prefetch FIFO.
// Optional VRAM_ARB_STATS_EN adds saturating stall/underflow counters.
module vram_scan_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WM     = 2,
  parameter int FB_WORDS   = 16384
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              frame_i,
  input  logic              pix_rd_i,
  output logic [DATA_W-1:0] pix_data_o,
  output logic              pix_valid_o,
  output logic              underflow_o,
  input  logic              gfx_sel_i,
  input  logic              gfx_wr_i,
  input  logic [3:0]        gfx_mask_i,
  input  logic [ADDR_W-1:0] gfx_addr_i,
  input  logic [DATA_W-1:0] gfx_data_i,
  output logic              gfx_ready_o,
  output logic [DATA_W-1:0] gfx_rdata_o,
  output logic              gfx_rvalid_o,
  output logic              ram_sel_o,
  output logic              ram_wr_o,
  output logic [3:0]        ram_mask_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stall_cnt_o,
  output logic [7:0]        under_cnt_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SA_W  = ADDR_W + 1;

  typedef enum logic {S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [SA_W-1:0]   r_scan_addr;
  logic              r_inflight;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic              r_underflow;
  logic              r_gfx_rvalid;

  logic [CNT_W-1:0]  w_level;
  logic              w_scan_ok;
  logic              w_urgent;
  logic              w_space;
  logic              w_scan_gnt;
  logic              w_gfx_gnt;
  logic              w_push;
  logic              w_pop;

  // Scans are held off in the frame_i cycle so no stale word returns after the flush.
  assign w_level    = r_count + CNT_W'(r_inflight);
  assign w_scan_ok  = reset_n_i && !frame_i && (r_state == S_RUN);
  assign w_urgent   = w_scan_ok && (w_level <= CNT_W'(LOW_WM));
  assign w_space    = w_scan_ok && (w_level < CNT_W'(FIFO_DEPTH));
  assign w_gfx_gnt  = reset_n_i && gfx_sel_i && !w_urgent;
  assign w_scan_gnt = w_urgent || (!gfx_sel_i && w_space);

  assign ram_sel_o  = w_scan_gnt || w_gfx_gnt;
  assign ram_wr_o   = w_gfx_gnt && gfx_wr_i;
  assign ram_mask_o = ram_wr_o ? gfx_mask_i : 4'hF;
  assign ram_addr_o = w_scan_gnt ? r_scan_addr[ADDR_W-1:0] : gfx_addr_i;
  assign ram_data_o = gfx_data_i;

  assign gfx_ready_o  = w_gfx_gnt;
  assign gfx_rdata_o  = ram_data_i;
  assign gfx_rvalid_o = r_gfx_rvalid;

  assign w_push = r_inflight && !frame_i;
  assign w_pop  = pix_rd_i && (r_count != '0) && !frame_i;

  assign pix_data_o  = r_mem[r_rd_ptr];
  assign pix_valid_o = (r_count != '0);
  assign underflow_o = r_underflow;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= ram_data_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      r_state      <= S_RUN;
      r_scan_addr  <= '0;
      r_inflight   <= 1'b0;
      r_gfx_rvalid <= 1'b0;
    end else begin
      r_inflight   <= w_scan_gnt;
      r_gfx_rvalid <= w_gfx_gnt && !gfx_wr_i;
      if (frame_i) begin
        r_state     <= S_RUN;
        r_scan_addr <= '0;
      end else if (w_scan_gnt) begin
        r_scan_addr <= r_scan_addr + SA_W'(1);
        if (r_scan_addr + SA_W'(1) == SA_W'(FB_WORDS)) r_state <= S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i || frame_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (pix_rd_i && (r_count == '0)) r_underflow <= 1'b1;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [7:0]  r_under_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n_i || frame_i) begin
      r_stall_cnt <= '0;
      r_under_cnt <= '0;
    end else begin
      if (gfx_sel_i && !gfx_ready_o && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (pix_rd_i && (r_count == '0) && (r_under_cnt != '1)) r_under_cnt <= r_under_cnt + 8'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign under_cnt_o = r_under_cnt;
`endif

endmodule
